// File: rtl/serial_mag_compare_if.sv
// Bit-serial operand stream and result flags between the operand source and the comparator.
interface serial_mag_compare_if;
    logic inStart;
    logic inValid;
    logic inBitA;
    logic inBitB;
    logic outBusy;
    logic outDone;
    logic outSame;
    logic outDiff;
    logic outBig;
    logic outSmall;

    modport master (
        output inStart, inValid, inBitA, inBitB,
        input  outBusy, outDone, outSame, outDiff, outBig, outSmall
    );

    modport slave (
        input  inStart, inValid, inBitA, inBitB,
        output outBusy, outDone, outSame, outDiff, outBig, outSmall
    );
endinterface

// File: rtl/serial_mag_compare.sv
// MSB-first serial magnitude comparator: the first differing bit pair decides A>B or A<B,
// and the word-level Same/Diff/Big/Small flags are published with a one-cycle done pulse.
module serial_mag_compare #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_mag_compare_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        DEC_EQ = 2'b00,
        DEC_GT = 2'b01,
        DEC_LT = 2'b10
    } decision_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nx_s;
    decision_t       dec_r;
    decision_t       dec_nx_s;
    logic [3:0]      flags_r;      // {same, diff, big, small}
    logic [3:0]      flags_nx_s;
    logic            busy_r;
    logic            done_r;

    // Next-state, bit counter and decision update.
    always_comb begin
        state_nx_s = state_r;
        count_nx_s = count_r;
        dec_nx_s   = dec_r;
        case (state_r)
            ST_IDLE: begin
                // A bit pair presented alongside inStart is deliberately not consumed.
                if (bus.inStart) begin
                    state_nx_s = ST_SHIFT;
                    count_nx_s = {CW{1'b0}};
                    dec_nx_s   = DEC_EQ;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.inValid) begin
                    count_nx_s = count_r + CW'(1);
                    // Only the most significant differing pair decides; later bits are ignored.
                    if ((dec_r == DEC_EQ) && (bus.inBitA != bus.inBitB)) begin
                        dec_nx_s = bus.inBitA ? DEC_GT : DEC_LT;
                    end else begin
                        dec_nx_s = dec_r;
                    end
                    if (count_r == LAST_COUNT) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_SHIFT;
                    end
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                count_nx_s = {CW{1'b0}};
                dec_nx_s   = DEC_EQ;
            end
        endcase
    end

    // Result flags are loaded on entry to DONE so they appear together with outDone.
    always_comb begin
        flags_nx_s = flags_r;
        if (state_nx_s == ST_DONE) begin
            case (dec_nx_s)
                DEC_EQ:  flags_nx_s = 4'b1000;
                DEC_GT:  flags_nx_s = 4'b0110;
                DEC_LT:  flags_nx_s = 4'b0101;
                default: flags_nx_s = 4'b0000;
            endcase
        end else begin
            flags_nx_s = flags_r;
        end
    end

    // State, counter, decision and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            count_r <= {CW{1'b0}};
            dec_r   <= DEC_EQ;
            flags_r <= 4'b0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            count_r <= count_nx_s;
            dec_r   <= dec_nx_s;
            flags_r <= flags_nx_s;
            busy_r  <= (state_nx_s == ST_SHIFT);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    assign bus.outBusy  = busy_r;
    assign bus.outDone  = done_r;
    assign bus.outSame  = flags_r[3];
    assign bus.outDiff  = flags_r[2];
    assign bus.outBig   = flags_r[1];
    assign bus.outSmall = flags_r[0];
endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed and random compares of serial_mag_compare against word-level arithmetic.
module tb_serial_mag_compare;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    logic [3:0] prevFlags;

    serial_mag_compare_if bus ();

    serial_mag_compare #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (busy,done,same,diff,big,small)", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.outBusy, bus.outDone, bus.outSame, bus.outDiff, bus.outBig, bus.outSmall};
    endfunction

    // mode: 0 no stalls, 1 alternate stalls, 2 random stalls
    task automatic do_compare(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input int mode, input bit validAtStart, input bit pokeStart);
        int idx;
        bit alt;
        bit v;
        logic [3:0] expFlags;
        expFlags = {a == b, a != b, a > b, a < b};
        bus.inStart = 1'b1;
        bus.inValid = validAtStart;
        bus.inBitA  = ~a[7];
        bus.inBitB  = a[7];
        idx = 7;
        alt = 1'b0;
        while (idx >= 0) begin
            @(negedge clk);
            check({tag, "_shift"}, outs(), {2'b10, prevFlags});
            bus.inStart = pokeStart;
            case (mode)
                0:       v = 1'b1;
                1:       begin v = alt; alt = ~alt; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            if (v) begin
                bus.inValid = 1'b1;
                bus.inBitA  = a[idx];
                bus.inBitB  = b[idx];
                idx--;
            end else begin
                bus.inValid = 1'b0;
                bus.inBitA  = 1'($urandom);
                bus.inBitB  = 1'($urandom);
            end
        end
        @(negedge clk);
        bus.inValid = 1'b0;
        bus.inStart = pokeStart;
        check({tag, "_done"}, outs(), {2'b01, expFlags});
        @(negedge clk);
        bus.inStart = 1'b0;
        check({tag, "_idle"}, outs(), {2'b00, expFlags});
        prevFlags = expFlags;
    endtask

    initial begin
        total = 0;
        bad = 0;
        prevFlags = 4'b0000;
        reset_n = 1'b0;
        bus.inStart = 1'b1;
        bus.inValid = 1'b1;
        bus.inBitA = 1'b1;
        bus.inBitB = 1'b0;

        // Reset with toggling controls.
        @(negedge clk);
        check("reset_a", outs(), 6'b000000);
        bus.inStart = 1'b0;
        bus.inValid = 1'b0;
        @(negedge clk);
        check("reset_b", outs(), 6'b000000);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", outs(), 6'b000000);

        do_compare("eq_a5", 8'hA5, 8'hA5, 0, 1'b0, 1'b0);
        do_compare("gt_msb", 8'h80, 8'h7F, 0, 1'b0, 1'b0);
        do_compare("lt_lsb_stall", 8'h3C, 8'h3D, 1, 1'b0, 1'b0);
        do_compare("start_poke", 8'h5A, 8'hC3, 0, 1'b1, 1'b1);

        // Abort after four accepted bits.
        bus.inStart = 1'b1;
        bus.inValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.inStart = 1'b0;
            bus.inValid = 1'b1;
            bus.inBitA = 1'b1;
            bus.inBitB = 1'b0;
        end
        @(negedge clk);
        check("abort_busy", outs(), {2'b10, prevFlags});
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_reset_a", outs(), 6'b000000);
        bus.inStart = 1'b1;
        @(negedge clk);
        check("abort_reset_b", outs(), 6'b000000);
        reset_n = 1'b1;
        bus.inStart = 1'b0;
        bus.inValid = 1'b0;
        @(negedge clk);
        check("abort_no_done", outs(), 6'b000000);
        prevFlags = 4'b0000;
        do_compare("fresh_gt", 8'h01, 8'h00, 0, 1'b0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (n % 3 == 0) ? ra : 8'($urandom);
            do_compare("random", ra, rb, 2, n[0], n[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
